// File: rtl/event_conditioner.sv
// Raw input conditioner: per-channel synchroniser, debouncer and edge detector.
// Produces single-cycle event pulses, debounced levels and glitch reports.
module event_conditioner #(
    parameter int N_IN        = 2,
    parameter int SYNC_STAGES = 2,
    parameter int DEB_CYCLES  = 4,
    parameter int EDGE_MODE   = 0,
    parameter int CW          = 3
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            en,
    input  logic [N_IN-1:0] raw_i,
    output logic [N_IN-1:0] ev_o,
    output logic [N_IN-1:0] lvl_o,
    output logic [N_IN-1:0] glitch_o
);

    localparam logic [CW-1:0] CNT_LAST = CW'(DEB_CYCLES - 1);

    if (SYNC_STAGES < 2) begin : g_bad_sync
        $error("event_conditioner: SYNC_STAGES must be >= 2");
    end
    if (DEB_CYCLES < 1) begin : g_bad_deb
        $error("event_conditioner: DEB_CYCLES must be >= 1");
    end
    if ((2 ** CW) < DEB_CYCLES) begin : g_bad_cw
        $error("event_conditioner: 2**CW must be >= DEB_CYCLES");
    end

    for (genvar g = 0; g < N_IN; g++) begin : g_ch
        logic [SYNC_STAGES-1:0] sync_q;
        logic [CW-1:0]          cnt_q;
        logic                   lvl_q;
        logic                   ev_q;
        logic                   glitch_q;
        logic                   s;
        logic                   edge_hit;

        // The synchroniser keeps running while disabled so s is valid on re-enable.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                sync_q <= '0;
            end else begin
                sync_q <= {sync_q[SYNC_STAGES-2:0], raw_i[g]};
            end
        end

        assign s = sync_q[SYNC_STAGES-1];

        always_comb begin
            edge_hit = 1'b0;
            case (EDGE_MODE)
                0:       edge_hit = s;
                1:       edge_hit = ~s;
                default: edge_hit = 1'b1;
            endcase
        end

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                cnt_q    <= '0;
                lvl_q    <= 1'b0;
                ev_q     <= 1'b0;
                glitch_q <= 1'b0;
            end else if (!en) begin
                cnt_q    <= '0;
                ev_q     <= 1'b0;
                glitch_q <= 1'b0;
            end else begin
                ev_q     <= 1'b0;
                glitch_q <= 1'b0;
                if (s == lvl_q) begin
                    if (cnt_q != '0) begin
                        cnt_q    <= '0;
                        glitch_q <= 1'b1;
                    end
                end else if (cnt_q == CNT_LAST) begin
                    lvl_q <= s;
                    cnt_q <= '0;
                    ev_q  <= edge_hit;
                end else begin
                    cnt_q <= cnt_q + CW'(1);
                end
            end
        end

        assign ev_o[g]     = ev_q;
        assign lvl_o[g]    = lvl_q;
        assign glitch_o[g] = glitch_q;
    end

endmodule
